hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_pkg.sv | 36 +++
 rtl/hazard_stall_ctrl_if.sv | 36 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 14 +
 rtl/hazard_stall_ctrl.sv | 82 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline types: register index width, hazard FSM encoding and the
// bundle of pipeline-control enables driven by the stall controller.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 4;
  typedef logic [REG_W-1:0] regIdx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazState_e;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexBubble;
    logic ifidFlush;
    logic exmemHold;
    logic memwbHold;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = ctrl_t'(6'b110000);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000011);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(6'b111100);
  localparam ctrl_t CTRL_LUSTALL = ctrl_t'(6'b001000);

  // Front-end decision while the back end is free: miss > branch > load-use.
  function automatic ctrl_t runCtrl(logic miss, logic br, logic lu);
    if (miss)     return CTRL_FREEZE;
    else if (br)  return CTRL_FLUSH;
    else if (lu)  return CTRL_LUSTALL;
    else          return CTRL_IDLE;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from the pipeline registers and the control enables returned.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic        MemRead_IDEX;
  regIdx_t     DstReg1_in_from_IDEX;
  regIdx_t     SrcReg1_in_from_IFID;
  regIdx_t     SrcReg2_in_from_IFID;
  logic        Src1_used_IFID;
  logic        Src2_used_IFID;
  logic        Branch_taken_EX;
  logic        Dmem_miss;
  logic        Dmem_ready;
  logic        PC_write;
  logic        IFID_write;
  logic        IDEX_bubble;
  logic        IFID_flush;
  logic        EXMEM_hold;
  logic        MEMWB_hold;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  modport master (
    output MemRead_IDEX, DstReg1_in_from_IDEX, SrcReg1_in_from_IFID, SrcReg2_in_from_IFID,
           Src1_used_IFID, Src2_used_IFID, Branch_taken_EX, Dmem_miss, Dmem_ready,
    input  PC_write, IFID_write, IDEX_bubble, IFID_flush, EXMEM_hold, MEMWB_hold,
           stall_cnt, mem_timeout
  );

  modport slave (
    input  MemRead_IDEX, DstReg1_in_from_IDEX, SrcReg1_in_from_IFID, SrcReg2_in_from_IFID,
           Src1_used_IFID, Src2_used_IFID, Branch_taken_EX, Dmem_miss, Dmem_ready,
    output PC_write, IFID_write, IDEX_bubble, IFID_flush, EXMEM_hold, MEMWB_hold,
           stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Width-parameterised saturating up-counter.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes and a
// data-memory wait freeze with a timeout into a sticky error state.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_MAX = 255
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam int WCW = $clog2(TIMEOUT_MAX + 1);
  localparam logic [WCW:0] TO_LIM = (WCW + 1)'(TIMEOUT_MAX);

  hazState_e      state;
  logic [WCW-1:0] waitCnt;
  logic [WCW:0]   waitNext;
  logic           memTimeout;
  logic           match1, match2, loadUse;
  ctrl_t          ctrl;

  assign match1   = bus.SrcReg1_in_from_IFID == bus.DstReg1_in_from_IDEX;
  assign match2   = bus.SrcReg2_in_from_IFID == bus.DstReg1_in_from_IDEX;
  assign loadUse  = bus.MemRead_IDEX && (bus.DstReg1_in_from_IDEX != '0) &&
                    ((bus.Src1_used_IFID && match1) || (bus.Src2_used_IFID && match2));
  assign waitNext = {1'b0, waitCnt} + 1'b1;

  // Outputs are combinational so stalls and the ready release act in the same cycle.
  always_comb begin
    ctrl = CTRL_FREEZE;
    unique case (state)
      RUN:      ctrl = runCtrl(bus.Dmem_miss, bus.Branch_taken_EX, loadUse);
      MEM_WAIT: if (bus.Dmem_ready) ctrl = runCtrl(1'b0, bus.Branch_taken_EX, loadUse);
      default:  ctrl = CTRL_FREEZE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (bus.Dmem_miss) begin
          state   <= MEM_WAIT;
          waitCnt <= '0;
        end
        MEM_WAIT: begin
          // A miss coinciding with ready is treated as ready.
          if (bus.Dmem_ready) state <= RUN;
          else begin
            waitCnt <= waitNext[WCW-1:0];
            if (waitNext >= TO_LIM) begin
              state      <= ERROR;
              memTimeout <= 1'b1;
            end
          end
        end
        default: begin
          state      <= ERROR;
          memTimeout <= 1'b1;
        end
      endcase
    end
  end

  assign bus.PC_write    = ctrl.pcWrite;
  assign bus.IFID_write  = ctrl.ifidWrite;
  assign bus.IDEX_bubble = ctrl.idexBubble;
  assign bus.IFID_flush  = ctrl.ifidFlush;
  assign bus.EXMEM_hold  = ctrl.exmemHold;
  assign bus.MEMWB_hold  = ctrl.memwbHold;
  assign bus.mem_timeout = memTimeout;

  sat_counter #(.W(16)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pcWrite),
    .cnt   (bus.stall_cnt)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controllers (default and short timeout) share stimulus;
// a reference model pushes expected outputs, a negedge monitor compares them.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int TO_A = 255;
  localparam int TO_B = 4;
  localparam logic [5:0] E_IDLE = 6'b110000;
  localparam logic [5:0] E_FRZ  = 6'b000011;
  localparam logic [5:0] E_BR   = 6'b111100;
  localparam logic [5:0] E_LU   = 6'b001000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if ifA ();
  hazard_stall_ctrl_if ifB ();

  hazard_stall_ctrl #(.TIMEOUT_MAX(TO_A)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  hazard_stall_ctrl #(.TIMEOUT_MAX(TO_B)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));

  typedef struct packed {
    bit       mr;
    bit [3:0] dst, s1, s2;
    bit       u1, u2, br, miss, rdy;
  } stim_t;

  typedef struct {
    logic [5:0] ctl [2];
    int         stalls [2];
    bit         to [2];
  } exp_t;

  exp_t sbq[$];
  int   nChk = 0;
  int   nFail = 0;

  // Model: 0 = running, 1 = waiting on memory, 2 = timed out.
  int mode [2];
  int waits [2];
  int stalls [2];
  int toMax [2] = '{TO_A, TO_B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    ifA.MemRead_IDEX = s.mr;  ifB.MemRead_IDEX = s.mr;
    ifA.DstReg1_in_from_IDEX = s.dst;  ifB.DstReg1_in_from_IDEX = s.dst;
    ifA.SrcReg1_in_from_IFID = s.s1;   ifB.SrcReg1_in_from_IFID = s.s1;
    ifA.SrcReg2_in_from_IFID = s.s2;   ifB.SrcReg2_in_from_IFID = s.s2;
    ifA.Src1_used_IFID = s.u1;  ifB.Src1_used_IFID = s.u1;
    ifA.Src2_used_IFID = s.u2;  ifB.Src2_used_IFID = s.u2;
    ifA.Branch_taken_EX = s.br; ifB.Branch_taken_EX = s.br;
    ifA.Dmem_miss = s.miss;     ifB.Dmem_miss = s.miss;
    ifA.Dmem_ready = s.rdy;     ifB.Dmem_ready = s.rdy;
  endtask

  function automatic logic [5:0] frontEnd(input stim_t s);
    bit hazard;
    hazard = s.mr && s.dst != 0 && ((s.u1 && s.s1 == s.dst) || (s.u2 && s.s2 == s.dst));
    if (s.br)    return E_BR;
    if (hazard)  return E_LU;
    return E_IDLE;
  endfunction

  task automatic modelStep(input int i, input stim_t s, output logic [5:0] ctl);
    if (mode[i] == 2) ctl = E_FRZ;
    else if (mode[i] == 1 && !s.rdy) begin
      ctl = E_FRZ;
      waits[i]++;
      if (waits[i] >= toMax[i]) mode[i] = 2;
    end else if (mode[i] == 0 && s.miss) begin
      ctl = E_FRZ;
      mode[i] = 1;
      waits[i] = 0;
    end else begin
      ctl = frontEnd(s);
      mode[i] = 0;
    end
    if (!ctl[5] && stalls[i] < 65535) stalls[i]++;
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    for (int i = 0; i < 2; i++) begin
      e.stalls[i] = stalls[i];
      e.to[i]     = (mode[i] == 2);
      modelStep(i, s, e.ctl[i]);
    end
    sbq.push_back(e);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_ctlA"}, {ifA.PC_write, ifA.IFID_write, ifA.IDEX_bubble, ifA.IFID_flush,
                           ifA.EXMEM_hold, ifA.MEMWB_hold}, E_IDLE);
    check({tag, "_ctlB"}, {ifB.PC_write, ifB.IFID_write, ifB.IDEX_bubble, ifB.IFID_flush,
                           ifB.EXMEM_hold, ifB.MEMWB_hold}, E_IDLE);
    check({tag, "_stallA"}, ifA.stall_cnt, 0);
    check({tag, "_stallB"}, ifB.stall_cnt, 0);
    check({tag, "_toA"}, ifA.mem_timeout, 0);
    check({tag, "_toB"}, ifB.mem_timeout, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must be idle at once.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    apply('0);
    #1;
    checkIdle("async_reset");
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; waits[i] = 0; stalls[i] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s.mr   = 1'($urandom % 2);
    s.dst  = 4'($urandom % 4);
    s.s1   = 4'($urandom % 4);
    s.s2   = 4'($urandom % 4);
    s.u1   = 1'($urandom % 2);
    s.u2   = 1'($urandom % 2);
    s.br   = ($urandom % 6) == 0;
    s.miss = ($urandom % 10) == 0;
    s.rdy  = ($urandom % 3) == 0;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("ctlA", {ifA.PC_write, ifA.IFID_write, ifA.IDEX_bubble, ifA.IFID_flush,
                       ifA.EXMEM_hold, ifA.MEMWB_hold}, e.ctl[0]);
        check("ctlB", {ifB.PC_write, ifB.IFID_write, ifB.IDEX_bubble, ifB.IFID_flush,
                       ifB.EXMEM_hold, ifB.MEMWB_hold}, e.ctl[1]);
        check("stallA", ifA.stall_cnt, e.stalls[0]);
        check("stallB", ifB.stall_cnt, e.stalls[1]);
        check("timeoutA", ifA.mem_timeout, e.to[0]);
        check("timeoutB", ifB.mem_timeout, e.to[1]);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; waits[i] = 0; stalls[i] = 0;
    end
    apply('0);
    #12;
    checkIdle("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load R3 followed by a consumer of R3, then load to R0.
    s = '0; s.mr = 1; s.dst = 3; s.s1 = 3; s.u1 = 1;
    cycle(s);
    cycle('0);
    s = '0; s.mr = 1; s.dst = 0; s.s1 = 0; s.u1 = 1;
    cycle(s);
    // Load-use on source 2 together with a taken branch.
    s = '0; s.mr = 1; s.dst = 5; s.s2 = 5; s.u2 = 1; s.br = 1;
    cycle(s);
    cycle('0);

    // Miss, five waits, ready: B times out after its fourth wait.
    s = '0; s.miss = 1;
    cycle(s);
    repeat (5) cycle('0);
    s = '0; s.rdy = 1; s.miss = 1; s.br = 1;
    cycle(s);
    repeat (3) cycle('0);
    doReset();
    cycle('0);

    // Reset while waiting on memory.
    s = '0; s.miss = 1;
    cycle(s);
    cycle('0);
    doReset();

    for (int blk = 0; blk < 4; blk++) begin
      repeat (300) cycle(randStim());
      doReset();
    end
    cycle('0);

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    nChk++;
    if (sbq.size() != 0) begin
      nFail++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
